dither_frame_ctrl: RTL and testbench

//  Sequencer for the per-channel 8->4 bit dithering datapath of the VGA serial display.
//  - Derives the visible-area qualifier and frame/line timing pulses from the VGA pixel counters.
//  - Debounces the user mode switch; commits bypass/dither mode changes only at frame start (no mid-frame tearing).
//  - Issues the error-state clear to the dither units at frame start.

---
 rtl/dither_frame_ctrl.sv | 144 ++++++++++++++
 tb/tb_dither_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_frame_ctrl.sv
// dither_frame_ctrl: frame/line timing, visible qualifier, switch debounce and
// frame-aligned bypass/dither mode commit for the VGA dithering datapath.
// Optional frame counter enabled by defining DITH_FRAME_CNT_EN.
module dither_frame_ctrl #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned PIPE_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       sw_in,
  output logic       visible,
  output logic       dith_en,
  output logic       frame_start,
  output logic       line_start,
  output logic       err_clr,
  output logic       mode_pend,
  output logic [7:0] frame_cnt
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    ST_BYPASS   = 2'd0,
    ST_PEND_ON  = 2'd1,
    ST_DITHER   = 2'd2,
    ST_PEND_OFF = 2'd3
  } state_t;

  logic             tick_c;
  logic             frame_start_q, frame_start_d;
  logic             line_start_q, line_start_d;
  logic             vis_r_q, vis_r_d;
  logic             sync1_q, sw_s_q;
  logic             sw_deb_q, sw_deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  state_t           state_q, state_d;
  logic             dith_en_q, dith_en_d;
  logic             mode_pend_q, mode_pend_d;

  assign tick_c = (hc == 10'd0) && (vc == 10'd0);

  // Timing compares; out-of-range counters fall out as blanking naturally
  always_comb begin
    frame_start_d = tick_c;
    line_start_d  = (hc == 10'd0);
    vis_r_d       = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
  end

  // Debounce: accept sw_s once it has disagreed with sw_deb for DEB_CYCLES samples
  always_comb begin
    sw_deb_d  = sw_deb_q;
    deb_cnt_d = '0;
    if (sw_s_q != sw_deb_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        sw_deb_d = sw_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Mode FSM: requests wait for frame start; a reverted request aborts first
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BYPASS:   if (sw_deb_q)   state_d = ST_PEND_ON;
      ST_PEND_ON:  if (!sw_deb_q)  state_d = ST_BYPASS;
                   else if (tick_c) state_d = ST_DITHER;
      ST_DITHER:   if (!sw_deb_q)  state_d = ST_PEND_OFF;
      ST_PEND_OFF: if (sw_deb_q)   state_d = ST_DITHER;
                   else if (tick_c) state_d = ST_BYPASS;
      default:     state_d = ST_BYPASS;
    endcase
    dith_en_d   = (state_d == ST_DITHER) || (state_d == ST_PEND_OFF);
    mode_pend_d = (state_d == ST_PEND_ON) || (state_d == ST_PEND_OFF);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      vis_r_q       <= 1'b0;
      sync1_q       <= 1'b0;
      sw_s_q        <= 1'b0;
      sw_deb_q      <= 1'b0;
      deb_cnt_q     <= '0;
      state_q       <= ST_BYPASS;
      dith_en_q     <= 1'b0;
      mode_pend_q   <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      vis_r_q       <= vis_r_d;
      sync1_q       <= sw_in;
      sw_s_q        <= sync1_q;
      sw_deb_q      <= sw_deb_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      dith_en_q     <= dith_en_d;
      mode_pend_q   <= mode_pend_d;
    end
  end

  // Visible delay line aligning the qualifier with datapath latency
  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign visible = vis_r_q;
    end else begin : g_pipe
      logic [PIPE_LAT-1:0] vis_sr_q, vis_sr_d;
      always_comb vis_sr_d = PIPE_LAT'({vis_sr_q, vis_r_q});
      // Shift register stages
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vis_sr_q <= '0;
        else     vis_sr_q <= vis_sr_d;
      end
      assign visible = vis_sr_q[PIPE_LAT-1];
    end
  endgenerate

`ifdef DITH_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = tick_c ? frame_cnt_q + 8'd1 : frame_cnt_q;
  // Frame counter, advances with each frame_start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= 8'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end
  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

  assign frame_start = frame_start_q;
  assign err_clr     = frame_start_q;
  assign line_start  = line_start_q;
  assign dith_en     = dith_en_q;
  assign mode_pend   = mode_pend_q;

endmodule

// File: tb/tb_dither_frame_ctrl.sv
// Self-checking bench for dither_frame_ctrl (DEB_CYCLES=4, PIPE_LAT=1).
module tb_dither_frame_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hc, vc;
  logic       sw_in;
  logic       visible, dith_en, frame_start, line_start, err_clr, mode_pend;
  logic [7:0] frame_cnt;

  int vectors = 0;
  int errors  = 0;

  dither_frame_ctrl #(
    .H_VISIBLE(640), .V_VISIBLE(480), .DEB_CYCLES(DEB), .PIPE_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .hc(hc), .vc(vc), .sw_in(sw_in),
    .visible(visible), .dith_en(dith_en), .frame_start(frame_start),
    .line_start(line_start), .err_clr(err_clr), .mode_pend(mode_pend),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: abstract mode/pending state and input histories
  bit m_s1, m_s2, m_deb, m_mode, m_pend, m_fs, m_ls, m_v1, m_v2;
  bit m_hist[$];
  int m_fcnt;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_mode = 0; m_pend = 0;
    m_fs = 0; m_ls = 0; m_v1 = 0; m_v2 = 0; m_fcnt = 0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    bit tick, deb_old;
    int mism;
    if (rst) begin
      model_reset();
      return;
    end
    tick    = (hc == 0) && (vc == 0);
    deb_old = m_deb;
    m_v2 = m_v1;
    m_v1 = (int'(hc) < 640) && (int'(vc) < 480);
    m_fs = tick;
    m_ls = (hc == 0);
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    mism = 0;
    foreach (m_hist[i]) if (m_hist[i] != m_deb) mism++;
    if (mism == DEB) begin
      m_deb = ~m_deb;
      m_hist.delete();
    end
    m_s2 = m_s1;
    m_s1 = sw_in;
    if (m_pend) begin
      if (deb_old == m_mode) m_pend = 0;
      else if (tick) begin
        m_mode = ~m_mode;
        m_pend = 0;
      end
    end else if (deb_old != m_mode) begin
      m_pend = 1;
    end
    if (tick) m_fcnt = (m_fcnt + 1) % 256;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t hc=%0d vc=%0d", name, act, exp, $time, hc, vc);
    end
  endtask

  task automatic check_all();
    int exp_fc;
`ifdef DITH_FRAME_CNT_EN
    exp_fc = m_fcnt;
`else
    exp_fc = 0;
`endif
    chk("frame_start", int'(frame_start), int'(m_fs));
    chk("err_clr",     int'(err_clr),     int'(m_fs));
    chk("line_start",  int'(line_start),  int'(m_ls));
    chk("visible",     int'(visible),     int'(m_v2));
    chk("dith_en",     int'(dith_en),     int'(m_mode));
    chk("mode_pend",   int'(mode_pend),   int'(m_pend));
    chk("frame_cnt",   int'(frame_cnt),   exp_fc);
  endtask

  task automatic cyc(input logic [9:0] h, input logic [9:0] v, input logic s);
    hc = h; vc = v; sw_in = s;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       fs;
    logic       ls;
    logic       vis;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit rsw;
    int r;
    logic [9:0] rh, rv;

    // visible column = qualifier of the previous row's counters
    tbl[0]  = '{10'd0,    10'd0,    1'b1, 1'b1, 1'b0};
    tbl[1]  = '{10'd1,    10'd0,    1'b0, 1'b0, 1'b1};
    tbl[2]  = '{10'd639,  10'd10,   1'b0, 1'b0, 1'b1};
    tbl[3]  = '{10'd640,  10'd10,   1'b0, 1'b0, 1'b1};
    tbl[4]  = '{10'd0,    10'd10,   1'b0, 1'b1, 1'b0};
    tbl[5]  = '{10'd0,    10'd479,  1'b0, 1'b1, 1'b1};
    tbl[6]  = '{10'd0,    10'd480,  1'b0, 1'b1, 1'b1};
    tbl[7]  = '{10'd0,    10'd0,    1'b1, 1'b1, 1'b0};
    tbl[8]  = '{10'd800,  10'd0,    1'b0, 1'b0, 1'b1};
    tbl[9]  = '{10'd1023, 10'd1023, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{10'd0,    10'd524,  1'b0, 1'b1, 1'b0};
    tbl[11] = '{10'd5,    10'd5,    1'b0, 1'b0, 1'b0};
    tbl[12] = '{10'd700,  10'd500,  1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; hc = 10'd700; vc = 10'd500; sw_in = 1'b0;
    model_reset();
    repeat (3) cyc(10'd700, 10'd500, 1'b0);
    chk("rst_dith_en", int'(dith_en), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    rst = 1'b0;
    repeat (3) cyc(10'd700, 10'd500, 1'b0);

    // Timing table
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].hc, tbl[i].vc, 1'b0);
      chk("tbl_frame_start", int'(frame_start), int'(tbl[i].fs));
      chk("tbl_err_clr",     int'(err_clr),     int'(tbl[i].fs));
      chk("tbl_line_start",  int'(line_start),  int'(tbl[i].ls));
      chk("tbl_visible",     int'(visible),     int'(tbl[i].vis));
    end

    // Short bounce never reaches acceptance
    repeat (2) cyc(10'd700, 10'd300, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc(10'd700, 10'd300, 1'b0);
      chk("bounce_mode_pend", int'(mode_pend), 0);
    end

    // Held switch: pending after 2 sync + 4 debounce + 1 FSM cycles
    for (int i = 1; i <= 7; i++) begin
      cyc(10'd700, 10'd300, 1'b1);
      chk("hold_mode_pend", int'(mode_pend), (i == 7) ? 1 : 0);
      chk("hold_dith_en", int'(dith_en), 0);
    end

    // Commit waits for frame start
    cyc(10'd10, 10'd200, 1'b1);
    cyc(10'd0, 10'd201, 1'b1);
    chk("commit_wait_dith_en", int'(dith_en), 0);
    chk("commit_wait_pend", int'(mode_pend), 1);
    cyc(10'd0, 10'd0, 1'b1);
    chk("commit_fs", int'(frame_start), 1);
    chk("commit_dith_en", int'(dith_en), 1);
    chk("commit_pend", int'(mode_pend), 0);

    // Abort: PEND_OFF reverted before the frame ends
    repeat (7) cyc(10'd700, 10'd300, 1'b0);
    chk("pend_off_pend", int'(mode_pend), 1);
    chk("pend_off_dith_en", int'(dith_en), 1);
    repeat (7) cyc(10'd700, 10'd300, 1'b1);
    chk("abort_pend", int'(mode_pend), 0);
    cyc(10'd0, 10'd0, 1'b1);
    chk("abort_tick_dith_en", int'(dith_en), 1);

    // Debounce completes on the tick cycle: commit slips one frame
    repeat (5) cyc(10'd700, 10'd300, 1'b0);
    cyc(10'd0, 10'd0, 1'b0);
    chk("late_fs", int'(frame_start), 1);
    chk("late_dith_en", int'(dith_en), 1);
    chk("late_pend", int'(mode_pend), 0);
    cyc(10'd700, 10'd300, 1'b0);
    chk("late_pend_next", int'(mode_pend), 1);
    repeat (3) cyc(10'd100, 10'd100, 1'b0);
    cyc(10'd0, 10'd0, 1'b0);
    chk("late_commit_dith_en", int'(dith_en), 0);
    chk("late_commit_pend", int'(mode_pend), 0);

    // Asynchronous reset mid-line, release at hc=5 vc=3
    repeat (7) cyc(10'd300, 10'd100, 1'b1);
    cyc(10'd301, 10'd100, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_visible", int'(visible), 0);
    chk("arst_mode_pend", int'(mode_pend), 0);
    check_all();
    repeat (2) cyc(10'd302, 10'd100, 1'b1);
    rst = 1'b0;
    for (int i = 5; i < 12; i++) begin
      cyc(10'(i), 10'd3, 1'b0);
      chk("post_rst_fs", int'(frame_start), 0);
    end
    cyc(10'd0, 10'd0, 1'b0);
    chk("post_rst_first_fs", int'(frame_start), 1);

    // Randomized traffic against the model
    rsw = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 11) == 0) rsw = ~rsw;
      r = $urandom_range(0, 7);
      case (r)
        0: begin rh = 10'd0; rv = 10'd0; end
        1: begin rh = 10'd0; rv = 10'($urandom_range(0, 1023)); end
        2: begin rh = 10'($urandom_range(638, 641)); rv = 10'($urandom_range(0, 1023)); end
        3: begin rh = 10'($urandom_range(0, 1023)); rv = 10'($urandom_range(478, 481)); end
        default: begin rh = 10'($urandom_range(0, 1023)); rv = 10'($urandom_range(0, 1023)); end
      endcase
      cyc(rh, rv, rsw);
    end

    // Frame counter over 257 frames
    cyc(10'd50, 10'd50, 1'b0);
    rst = 1'b1;
    cyc(10'd50, 10'd50, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 257; i++) cyc(10'd0, 10'd0, 1'b0);
    cyc(10'd1, 10'd0, 1'b0);
`ifdef DITH_FRAME_CNT_EN
    chk("frame_cnt_257", int'(frame_cnt), 1);
`else
    chk("frame_cnt_257", int'(frame_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
